cla_serial_adder: RTL and testbench

Sequential multi-nibble adder that adds two WIDTH-bit operands four bits per clock through the team's combinational `carry_lookahead` unit. It sits directly around that unit: upstream, it generates per-nibble propagate/generate terms; downstream, it consumes the four carries to form sum bits and chains `co4_o` into the next nibble through a carry register. A start/busy/done handshake frames each operation, and the result stays registered until the next operation starts.

---
 rtl/cla_serial_pkg.sv | 14 +
 rtl/cla_serial_adder_carry_lookahead.sv | 30 +++
 rtl/cla_serial_adder.sv | 142 ++++++++++++++
 tb/tb_cla_serial_adder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cla_serial_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
package cla_serial_pkg;

   // Width of one serial step; the carry_lookahead unit handles exactly 4 bits.
   localparam int NIBBLE = 4;

   // Operation sequencing: wait for start, walk the nibbles, flag completion.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } cla_state_t;

endpackage : cla_serial_pkg

// File: rtl/cla_serial_adder_carry_lookahead.sv
// 4-bit carry-lookahead unit: derives all four nibble carries from the
// per-bit propagate/generate terms and the incoming carry in a single level.
module carry_lookahead (
   input  logic ci_i,
   input  logic p0_i,
   input  logic p1_i,
   input  logic p2_i,
   input  logic p3_i,
   input  logic g0_i,
   input  logic g1_i,
   input  logic g2_i,
   input  logic g3_i,
   output logic co1_o,
   output logic co2_o,
   output logic co3_o,
   output logic co4_o
);

   // Flattened lookahead equations so no carry depends on a previous carry output.
   always_comb begin
      co1_o = g0_i | (p0_i & ci_i);
      co2_o = g1_i | (p1_i & g0_i) | (p1_i & p0_i & ci_i);
      co3_o = g2_i | (p2_i & g1_i) | (p2_i & p1_i & g0_i)
            | (p2_i & p1_i & p0_i & ci_i);
      co4_o = g3_i | (p3_i & g2_i) | (p3_i & p2_i & g1_i)
            | (p3_i & p2_i & p1_i & g0_i)
            | (p3_i & p2_i & p1_i & p0_i & ci_i);
   end

endmodule : carry_lookahead

// File: rtl/cla_serial_adder.sv
// Nibble-serial adder: one 4-bit carry-lookahead step per clock, with the
// nibble carry-out chained through a register into the next step.
module cla_serial_adder
   import cla_serial_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             overflow_o
);

   localparam int N  = WIDTH / NIBBLE;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   cla_state_t        state_q, state_d;
   logic [KW-1:0]     k_q, k_d;
   logic              carry_q, carry_d;
   logic [WIDTH-1:0]  a_q, b_q;
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic              cout_q, cout_d;
   logic              ovf_q, ovf_d;

   logic              accept;
   logic [NIBBLE-1:0] a_nib, b_nib, p_nib, g_nib, s_nib;
   logic              co1, co2, co3, co4;

   assign accept = (state_q == ST_IDLE) && start_i;

   // Select the active nibble and form its propagate/generate terms.
   always_comb begin
      a_nib = a_q[int'(k_q)*NIBBLE +: NIBBLE];
      b_nib = b_q[int'(k_q)*NIBBLE +: NIBBLE];
      p_nib = a_nib ^ b_nib;
      g_nib = a_nib & b_nib;
   end

   carry_lookahead u_cla (
      .ci_i  (carry_q),
      .p0_i  (p_nib[0]),
      .p1_i  (p_nib[1]),
      .p2_i  (p_nib[2]),
      .p3_i  (p_nib[3]),
      .g0_i  (g_nib[0]),
      .g1_i  (g_nib[1]),
      .g2_i  (g_nib[2]),
      .g3_i  (g_nib[3]),
      .co1_o (co1),
      .co2_o (co2),
      .co3_o (co3),
      .co4_o (co4)
   );

   // Sum bits: each bit's propagate XORed with the carry arriving at that bit.
   always_comb begin
      s_nib = p_nib ^ {co3, co2, co1, carry_q};
   end

   // Next-state logic: accept in IDLE, one nibble per RUN cycle, single DONE cycle.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_RUN;
               k_d     = '0;
               carry_d = cin_i;
               sum_d   = '0;
               cout_d  = 1'b0;
               ovf_d   = 1'b0;
            end
         end
         ST_RUN: begin
            sum_d[int'(k_q)*NIBBLE +: NIBBLE] = s_nib;
            carry_d = co4;
            if (k_q == K_LAST) begin
               // Top nibble: its carry-out is the final carry, and the carries
               // into/out of the sign bit decide two's-complement overflow.
               cout_d  = co4;
               ovf_d   = co3 ^ co4;
               state_d = ST_DONE;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control and result registers; reset aborts any operation in flight.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   // Operand capture on the accepting edge; only read during RUN, so no reset needed.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         a_q <= a_i;
         b_q <= b_i;
      end
   end

   assign busy_o     = (state_q != ST_IDLE);
   assign done_o     = (state_q == ST_DONE);
   assign sum_o      = sum_q;
   assign cout_o     = cout_q;
   assign overflow_o = ovf_q;

endmodule : cla_serial_adder

// File: tb/tb_cla_serial_adder.sv
// Directed bench for the nibble-serial adder at WIDTH=16 and WIDTH=4.
module tb_cla_serial_adder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        start = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        cin = 1'b0;
   logic        busy, done, cout, ovf;
   logic [15:0] sum;

   logic        start4 = 1'b0;
   logic [3:0]  a4 = '0;
   logic [3:0]  b4 = '0;
   logic        cin4 = 1'b0;
   logic        busy4, done4, cout4, ovf4;
   logic [3:0]  sum4;

   int checks = 0;
   int errors = 0;

   cla_serial_adder #(.WIDTH(16)) dut16 (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .start_i    (start),
      .a_i        (a),
      .b_i        (b),
      .cin_i      (cin),
      .busy_o     (busy),
      .done_o     (done),
      .sum_o      (sum),
      .cout_o     (cout),
      .overflow_o (ovf)
   );

   cla_serial_adder #(.WIDTH(4)) dut4 (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .start_i    (start4),
      .a_i        (a4),
      .b_i        (b4),
      .cin_i      (cin4),
      .busy_o     (busy4),
      .done_o     (done4),
      .sum_o      (sum4),
      .cout_o     (cout4),
      .overflow_o (ovf4)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation time limit reached");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Walk one 16-bit operation from the cycle after acceptance to IDLE,
   // reporting when done was seen and how many cycles busy was high.
   task automatic track(output int done_at, output int busy_cnt);
      done_at  = -1;
      busy_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (busy) busy_cnt++;
         if (done) done_at = i;
         if (!busy) break;
         @(posedge clk); #1;
      end
   endtask

   task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic cv, input logic [15:0] es, input logic ec, input logic eo);
      int d_at, b_cnt;
      a = av; b = bv; cin = cv; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, "_clr"}, 32'(sum), 32'h0);
      track(d_at, b_cnt);
      chk({tag, "_lat"}, 32'(d_at), 32'd4);
      chk({tag, "_busy"}, 32'(b_cnt), 32'd5);
      chk({tag, "_sum"}, 32'(sum), 32'(es));
      chk({tag, "_cout"}, 32'(cout), 32'(ec));
      chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
   endtask

   initial begin
      int d_at, b_cnt, dcount;

      // Reset state, asserted asynchronously before any clock edge
      #1;
      chk("rst_sum", 32'(sum), 32'h0);
      chk("rst_cout", 32'(cout), 32'h0);
      chk("rst_ovf", 32'(ovf), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_sum4", 32'(sum4), 32'h0);
      chk("rst_busy4", 32'(busy4), 32'h0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic additions and carry/overflow boundaries
      run_op("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("hold_sum", 32'(sum), 32'h5555);
      chk("hold_done", 32'(done), 32'h0);
      run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("sovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_op("cin", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);

      // Start pulse during the second RUN cycle must be ignored
      a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      d_at = -1;
      for (int i = 0; i < 20; i++) begin
         if (done) d_at = i;
         if (!busy) break;
         if (i == 1) begin start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; end
         if (i == 2) start = 1'b0;
         @(posedge clk); #1;
      end
      chk("ign_lat", 32'(d_at), 32'd4);
      chk("ign_sum", 32'(sum), 32'h3333);
      chk("ign_cout", 32'(cout), 32'h0);

      // Start held high: relaunch only after DONE, every N+2 cycles
      a = 16'h0F0F; b = 16'h0101; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      track(d_at, b_cnt);
      chk("held1_lat", 32'(d_at), 32'd4);
      chk("held1_sum", 32'(sum), 32'h1010);
      chk("held_gap_busy", 32'(busy), 32'h0);
      @(posedge clk); #1;
      chk("held2_busy", 32'(busy), 32'h1);
      chk("held2_clr", 32'(sum), 32'h0);
      start = 1'b0;
      track(d_at, b_cnt);
      chk("held2_lat", 32'(d_at), 32'd4);
      chk("held2_sum", 32'(sum), 32'h1010);

      // Reset during nibble 2 aborts the operation
      a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid_partial", 32'(sum), 32'h0055);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_sum", 32'(sum), 32'h0);
      chk("mid_busy", 32'(busy), 32'h0);
      chk("mid_done", 32'(done), 32'h0);
      chk("mid_cout", 32'(cout), 32'h0);
      chk("mid_ovf", 32'(ovf), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      dcount = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (done) dcount++;
      end
      chk("mid_nodone", 32'(dcount), 32'h0);
      run_op("after_rst", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);

      // WIDTH=4: single-nibble operation, done one cycle after acceptance
      a4 = 4'h9; b4 = 4'h8; cin4 = 1'b0; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      chk("w4_busy", 32'(busy4), 32'h1);
      chk("w4_early", 32'(done4), 32'h0);
      @(posedge clk); #1;
      chk("w4_done", 32'(done4), 32'h1);
      chk("w4_sum", 32'(sum4), 32'h1);
      chk("w4_cout", 32'(cout4), 32'h1);
      chk("w4_ovf", 32'(ovf4), 32'h1);
      @(posedge clk); #1;
      chk("w4_done_off", 32'(done4), 32'h0);
      chk("w4_idle", 32'(busy4), 32'h0);
      chk("w4_hold", 32'(sum4), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_cla_serial_adder
